// File: rtl/sdm_ni_tx.sv
// Clocked NI transmitter: buffers valid/ready flits and drives a 1-of-4 four-phase RTZ
// router port. Optional macro NI_CHANNEL_SLICING_EN widens eof/ack to one bit per sub-channel.
module sdm_ni_tx #(
  parameter int unsigned DW    = 32,
  parameter int unsigned SCN   = DW / 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_data,
  input  logic           in_tail,
  output logic [SCN-1:0] lo0,
  output logic [SCN-1:0] lo1,
  output logic [SCN-1:0] lo2,
  output logic [SCN-1:0] lo3,
`ifdef NI_CHANNEL_SLICING_EN
  output logic [SCN-1:0] lo4,
  input  logic [SCN-1:0] loa,
`else
  output logic           lo4,
  input  logic           loa,
`endif
  output logic [AW:0]    fifo_cnt,
  output logic           busy
);

`ifdef NI_CHANNEL_SLICING_EN
  localparam int unsigned EofW = SCN;
`else
  localparam int unsigned EofW = 1;
`endif

  typedef enum logic [1:0] {StIdle, StData, StRtz} state_e;

  // FIFO storage: {tail, data}
  logic [DW:0]   mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          full, empty, push, pop;
  logic [DW:0]   head;

  logic [EofW-1:0] ack_meta_q, ack_s_q;
  logic            ack_hi, ack_lo;

  state_e          state_q, state_d;
  logic [SCN-1:0]  lo0_q, lo0_d, lo1_q, lo1_d, lo2_q, lo2_d, lo3_q, lo3_d;
  logic [EofW-1:0] lo4_q, lo4_d;

  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign in_ready = !full;
  assign push  = in_valid && in_ready;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign fifo_cnt = wr_ptr_q - rd_ptr_q;
  assign busy     = (state_q != StIdle) || !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_tail, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // loa is asynchronous to clk: two-flop synchroniser per bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta_q <= '0;
      ack_s_q    <= '0;
    end else begin
      ack_meta_q <= loa;
      ack_s_q    <= ack_meta_q;
    end
  end

  // Mixed ack bits count as neither high nor low
  assign ack_hi = &ack_s_q;
  assign ack_lo = ~|ack_s_q;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    lo0_d   = lo0_q;
    lo1_d   = lo1_q;
    lo2_d   = lo2_q;
    lo3_d   = lo3_q;
    lo4_d   = lo4_q;
    case (state_q)
      StIdle: begin
        lo0_d = '0;
        lo1_d = '0;
        lo2_d = '0;
        lo3_d = '0;
        lo4_d = '0;
        if (!empty && ack_lo) begin
          pop = 1'b1;
          for (int unsigned i = 0; i < SCN; i++) begin
            lo0_d[i] = (head[2*i +: 2] == 2'd0);
            lo1_d[i] = (head[2*i +: 2] == 2'd1);
            lo2_d[i] = (head[2*i +: 2] == 2'd2);
            lo3_d[i] = (head[2*i +: 2] == 2'd3);
          end
          lo4_d   = {EofW{head[DW]}};
          state_d = StData;
        end
      end
      StData: begin
        if (ack_hi) begin
          lo0_d   = '0;
          lo1_d   = '0;
          lo2_d   = '0;
          lo3_d   = '0;
          lo4_d   = '0;
          state_d = StRtz;
        end
      end
      StRtz: begin
        if (ack_lo) state_d = StIdle;
      end
      default: begin
        lo0_d   = '0;
        lo1_d   = '0;
        lo2_d   = '0;
        lo3_d   = '0;
        lo4_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lo0_q   <= '0;
      lo1_q   <= '0;
      lo2_q   <= '0;
      lo3_q   <= '0;
      lo4_q   <= '0;
    end else begin
      state_q <= state_d;
      lo0_q   <= lo0_d;
      lo1_q   <= lo1_d;
      lo2_q   <= lo2_d;
      lo3_q   <= lo3_d;
      lo4_q   <= lo4_d;
    end
  end

  assign lo0 = lo0_q;
  assign lo1 = lo1_q;
  assign lo2 = lo2_q;
  assign lo3 = lo3_q;
  assign lo4 = lo4_q;

endmodule

// File: tb/tb_sdm_ni_tx.sv
// Directed self-checking bench for sdm_ni_tx (default DW=32, DEPTH=4).
module tb_sdm_ni_tx;
  localparam int DW = 32;
  localparam int SCN = 16;
  localparam int DEPTH = 4;
  localparam int AW = 2;
`ifdef NI_CHANNEL_SLICING_EN
  localparam int LW = SCN;
`else
  localparam int LW = 1;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic           in_tail;
  logic [SCN-1:0] lo0, lo1, lo2, lo3;
  logic [LW-1:0]  lo4;
  logic [LW-1:0]  loa;
  logic [AW:0]    fifo_cnt;
  logic           busy;
  logic [63:0]    rails;
  logic [LW-1:0]  all1;

  int tests = 0;
  int fails = 0;

  assign rails = {lo3, lo2, lo1, lo0};
  assign all1  = '1;

  always #5 clk = ~clk;

  sdm_ni_tx #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_tail  (in_tail),
    .lo0      (lo0),
    .lo1      (lo1),
    .lo2      (lo2),
    .lo3      (lo3),
    .lo4      (lo4),
    .loa      (loa),
    .fifo_cnt (fifo_cnt),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_one(input logic [DW-1:0] d, input logic t);
    in_valid = 1'b1;
    in_data  = d;
    in_tail  = t;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Full router handshake on the token currently in DATA; ends with FSM back in IDLE
  task automatic ack_cycle(input string tag, input logic [63:0] exp);
    loa = '1;
    wait_n(2);
    chk({tag, "_hold"}, rails, exp);
    wait_n(1);
    chk({tag, "_spacer"}, rails, 64'h0);
    loa = '0;
    wait_n(3);
  endtask

  logic [31:0] d3 [5];
  logic [63:0] e3 [5];

  initial begin
    d3 = '{32'h0000_0000, 32'h5555_5555, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h0000_FFFF};
    e3 = '{64'h0000_0000_0000_FFFF, 64'h0000_0000_FFFF_0000, 64'h0000_FFFF_0000_0000,
           64'hFFFF_0000_0000_0000, 64'h00FF_0000_0000_FF00};
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_tail = 1'b0; loa = '0;
    #1;
    chk("rst_rails", rails, 64'h0);
    chk("rst_lo4", 64'(lo4), 64'h0);
    chk("rst_cnt", 64'(fifo_cnt), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    wait_n(2);
    rst_n = 1'b1;
    #1 chk("rst_ready", 64'(in_ready), 64'h1);

    // Single non-tail flit of zeros
    push_one(32'h0, 1'b0);
    chk("t1_cnt", 64'(fifo_cnt), 64'h1);
    chk("t1_not_yet", rails, 64'h0);
    wait_n(1);
    chk("t1_rails", rails, 64'hFFFF);
    chk("t1_lo4", 64'(lo4), 64'h0);
    chk("t1_busy", 64'(busy), 64'h1);
    ack_cycle("t1", 64'hFFFF);
    chk("t1_idle", 64'(busy), 64'h0);

    // Tail flit, mixed symbols
    push_one(32'hE4E4_E4E4, 1'b1);
    wait_n(1);
    chk("t2_rails", rails, 64'h8888_4444_2222_1111);
    chk("t2_lo4", 64'(lo4), 64'(all1));
    ack_cycle("t2", 64'h8888_4444_2222_1111);

    // Backpressure with ack stalled low, then drain across pointer wrap
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = d3[i];
      in_tail = (i == 4);
      @(negedge clk);
    end
    in_data = 32'h1234_5678;
    in_tail = 1'b0;
    chk("t3_full_cnt", 64'(fifo_cnt), 64'h4);
    chk("t3_ready", 64'(in_ready), 64'h0);
    chk("t3_first", rails, e3[0]);
    wait_n(2);
    chk("t3_still_full", 64'(fifo_cnt), 64'h4);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ack_cycle("t3_hs", e3[i]);
      wait_n(1);
      chk("t3_rails", rails, e3[i+1]);
      chk("t3_cnt", 64'(fifo_cnt), 64'(3 - i));
    end
    chk("t3_tail", 64'(lo4), 64'(all1));
    ack_cycle("t3_last", e3[4]);
    chk("t3_drained", 64'(busy), 64'h0);
    chk("t3_cnt0", 64'(fifo_cnt), 64'h0);

    // Ack held high across reset release: no launch until it falls
    loa = '1;
    rst_n = 1'b0;
    wait_n(2);
    rst_n = 1'b1;
    wait_n(3);
    push_one(32'h5555_5555, 1'b0);
    wait_n(5);
    chk("t4_blocked", rails, 64'h0);
    chk("t4_cnt", 64'(fifo_cnt), 64'h1);
    loa = '0;
    wait_n(2);
    chk("t4_sync", rails, 64'h0);
    wait_n(1);
    chk("t4_launch", rails, 64'h0000_0000_FFFF_0000);
    ack_cycle("t4", 64'h0000_0000_FFFF_0000);

`ifdef NI_CHANNEL_SLICING_EN
    // Partial ack must not complete the handshake
    push_one(32'hAAAA_AAAA, 1'b1);
    wait_n(1);
    chk("t5_rails", rails, 64'h0000_FFFF_0000_0000);
    loa = 16'h7FFF;
    wait_n(5);
    chk("t5_partial", rails, 64'h0000_FFFF_0000_0000);
    ack_cycle("t5", 64'h0000_FFFF_0000_0000);
    chk("t5_idle", 64'(busy), 64'h0);
`endif

    // Reset while in DATA with two flits buffered
    in_valid = 1'b1;
    in_tail = 1'b0;
    in_data = 32'h0000_0000; @(negedge clk);
    in_data = 32'hFFFF_FFFF; @(negedge clk);
    in_data = 32'h5555_5555; @(negedge clk);
    in_valid = 1'b0;
    chk("t6_cnt", 64'(fifo_cnt), 64'h2);
    chk("t6_rails", rails, 64'hFFFF);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_rails", rails, 64'h0);
    chk("t6_rst_cnt", 64'(fifo_cnt), 64'h0);
    chk("t6_rst_busy", 64'(busy), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("t6_ready", 64'(in_ready), 64'h1);
    wait_n(4);
    chk("t6_lost", rails, 64'h0);
    chk("t6_cnt0", 64'(fifo_cnt), 64'h0);
    chk("t6_busy0", 64'(busy), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
